// File: rtl/pe_crossbar_nxm_reg_pkg.sv
// pe_crossbar_nxm_reg_pkg: shared select sizing macro, default source indices and FSM encodings
`ifndef PE_XBAR_SEL_W
`define PE_XBAR_SEL_W(n) ($clog2((n) + 1))
`endif
package pe_crossbar_nxm_reg_pkg;
  localparam int SRC_N = 0;
  localparam int SRC_S = 1;
  localparam int SRC_W = 2;
  localparam int SRC_E = 3;
  localparam int SRC_LSU = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
endpackage

// File: rtl/pe_crossbar_nxm_reg_if.sv
// pe_crossbar_nxm_reg_if: config, source and destination channels of the PE crossbar
// cfg_valid/cfg_sel/cfg_ready/cfg_busy: routing word handshake and drain indicator
// in_data/in_valid/in_ready: N_IN sources; out_data/out_valid/out_ready: N_OUT destinations
// PE_XBAR_STALL_CNT_EN adds stall_cnt (N_OUT x 16-bit per-output stall counters)
interface pe_crossbar_nxm_reg_if #(
  parameter int DATA_W = 32,
  parameter int N_IN = 5,
  parameter int N_OUT = 4,
  parameter int SEL_W = $clog2(N_IN + 1)
);
  logic cfg_valid;
  logic cfg_ready;
  logic cfg_busy;
  logic [N_OUT*SEL_W-1:0] cfg_sel;
  logic [N_IN*DATA_W-1:0] in_data;
  logic [N_IN-1:0] in_valid;
  logic [N_IN-1:0] in_ready;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic [N_OUT-1:0] out_valid;
  logic [N_OUT-1:0] out_ready;
`ifdef PE_XBAR_STALL_CNT_EN
  logic [N_OUT*16-1:0] stall_cnt;
`endif
  modport master (
    output cfg_valid, cfg_sel, in_data, in_valid, out_ready,
    input cfg_ready, cfg_busy, in_ready, out_data, out_valid
`ifdef PE_XBAR_STALL_CNT_EN
    , stall_cnt
`endif
  );
  modport slave (
    input cfg_valid, cfg_sel, in_data, in_valid, out_ready,
    output cfg_ready, cfg_busy, in_ready, out_data, out_valid
`ifdef PE_XBAR_STALL_CNT_EN
    , stall_cnt
`endif
  );
endinterface

// File: rtl/pe_xbar_out_stage.sv
// pe_xbar_out_stage: one-entry registered output stage with optional stall counter
// load/din: fork write; valid/dout/ready: downstream handshake
// PE_XBAR_STALL_CNT_EN adds clr (config apply) and stall_cnt (saturating 16-bit)
module pe_xbar_out_stage #(
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic ready,
`ifdef PE_XBAR_STALL_CNT_EN
  input  logic clr,
  output logic [15:0] stall_cnt,
`endif
  input  logic [DATA_W-1:0] din,
  output logic valid,
  output logic [DATA_W-1:0] dout
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      dout <= '0;
    end else begin
      valid <= load | (valid & ~ready);
      if (load) dout <= din;
    end
`ifdef PE_XBAR_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (clr) stall_cnt <= '0;
    else if (valid && !ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule

// File: rtl/pe_crossbar_nxm_reg.sv
// pe_crossbar_nxm_reg: registered N_IN x N_OUT PE operand crossbar with multicast and drained reconfig
// clk, rst_n (async active-low); bus: pe_crossbar_nxm_reg_if.slave (cfg, sources, destinations)
// PE_XBAR_STALL_CNT_EN adds per-output stall counters cleared on each config apply
module pe_crossbar_nxm_reg
  import pe_crossbar_nxm_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_IN = 5,
  parameter int N_OUT = 4
) (
  input logic clk,
  input logic rst_n,
  pe_crossbar_nxm_reg_if.slave bus
);
  localparam int SEL_W = $clog2(N_IN + 1);
  logic [1:0] state;
  logic [N_OUT*SEL_W-1:0] sel_q, shadow_q;
  logic [N_OUT-1:0] ov, can_acc, load;
  logic [N_IN-1:0] routed, blocked, rdy, fire;
  logic [DATA_W-1:0] din [N_OUT];
  logic [N_OUT*DATA_W-1:0] dout;
  logic cfg_hs, drained, apply;
  assign can_acc = ~ov | bus.out_ready;
  assign drained = &can_acc;
  assign cfg_hs = bus.cfg_valid && state != ST_DRAIN;
  // IDLE takes the word straight into the active select; DRAIN applies the shadow once every stage empties
  assign apply = (cfg_hs && state == ST_IDLE) || (state == ST_DRAIN && drained);
  assign bus.cfg_ready = state != ST_DRAIN;
  assign bus.cfg_busy = state == ST_DRAIN;
  assign bus.out_valid = ov;
  assign bus.out_data = dout;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      sel_q <= '1;
      shadow_q <= '1;
    end else begin
      if (apply) begin
        state <= ST_RUN;
        sel_q <= state == ST_IDLE ? bus.cfg_sel : shadow_q;
      end else if (cfg_hs) begin
        state <= ST_DRAIN;
        shadow_q <= bus.cfg_sel;
      end
    end
  // a source is ready only if every destination in its fork can accept, so multicast never splits
  always_comb begin
    routed = '0;
    blocked = '0;
    for (int o = 0; o < N_OUT; o++)
      for (int i = 0; i < N_IN; i++)
        if (sel_q[o*SEL_W +: SEL_W] == SEL_W'(i)) begin
          routed[i] = 1'b1;
          blocked[i] = blocked[i] | ~can_acc[o];
        end
  end
  assign rdy = state == ST_RUN ? routed & ~blocked : '0;
  assign fire = rdy & bus.in_valid;
  assign bus.in_ready = rdy;
  always_comb begin
    load = '0;
    for (int o = 0; o < N_OUT; o++) begin
      din[o] = '0;
      for (int i = 0; i < N_IN; i++)
        if (sel_q[o*SEL_W +: SEL_W] == SEL_W'(i)) begin
          load[o] = fire[i];
          din[o] = bus.in_data[i*DATA_W +: DATA_W];
        end
    end
  end
  for (genvar o = 0; o < N_OUT; o++) begin : g_out
    pe_xbar_out_stage #(.DATA_W(DATA_W)) u_stage (
      .clk(clk),
      .rst_n(rst_n),
      .load(load[o]),
      .ready(bus.out_ready[o]),
`ifdef PE_XBAR_STALL_CNT_EN
      .clr(apply),
      .stall_cnt(bus.stall_cnt[o*16 +: 16]),
`endif
      .din(din[o]),
      .valid(ov[o]),
      .dout(dout[o*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_pe_crossbar_nxm_reg.sv
// tb_pe_crossbar_nxm_reg: directed and randomized checks of the PE crossbar against a behavioural model
module tb_pe_crossbar_nxm_reg;
  localparam int NI = 5;
  localparam int NO = 4;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_bad = 0;
  int m_state;
  int m_sel [NO];
  int m_sh [NO];
  bit m_v [NO];
  logic [31:0] m_d [NO];
  int m_sc [NO];
  pe_crossbar_nxm_reg_if #(.DATA_W(32), .N_IN(NI), .N_OUT(NO)) bus ();
  pe_crossbar_nxm_reg #(.DATA_W(32), .N_IN(NI), .N_OUT(NO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [11:0] pk(input int a, input int b, input int c, input int d);
    return {d[2:0], c[2:0], b[2:0], a[2:0]};
  endfunction
  task automatic m_reset();
    m_state = 0;
    for (int o = 0; o < NO; o++) begin
      m_sel[o] = 7;
      m_sh[o] = 7;
      m_v[o] = 0;
      m_d[o] = '0;
      m_sc[o] = 0;
    end
  endtask
  function automatic bit m_can(input int o);
    return !m_v[o] || bus.out_ready[o];
  endfunction
  function automatic bit m_rdy(input int i);
    bit any = 0;
    bit ok = 1;
    if (m_state != 1) return 0;
    for (int o = 0; o < NO; o++)
      if (m_sel[o] == i) begin
        any = 1;
        if (!m_can(o)) ok = 0;
      end
    return any && ok;
  endfunction
  task automatic m_clock();
    bit fire [NI];
    bit hs;
    bit drn = 1;
    if (!rst_n) begin
      m_reset();
      return;
    end
    hs = bus.cfg_valid && m_state != 2;
    for (int o = 0; o < NO; o++) drn &= m_can(o);
    for (int i = 0; i < NI; i++) fire[i] = bus.in_valid[i] && m_rdy(i);
    for (int o = 0; o < NO; o++) begin
      if (m_v[o] && !bus.out_ready[o] && m_sc[o] < 65535) m_sc[o]++;
      if (m_sel[o] < NI && fire[m_sel[o]]) begin
        m_v[o] = 1;
        m_d[o] = bus.in_data[m_sel[o]*32 +: 32];
      end else if (bus.out_ready[o]) m_v[o] = 0;
    end
    if (m_state == 0 && hs) begin
      for (int o = 0; o < NO; o++) begin
        m_sel[o] = int'(bus.cfg_sel[o*3 +: 3]);
        m_sc[o] = 0;
      end
      m_state = 1;
    end else if (m_state == 1 && hs) begin
      for (int o = 0; o < NO; o++) m_sh[o] = int'(bus.cfg_sel[o*3 +: 3]);
      m_state = 2;
    end else if (m_state == 2 && drn) begin
      for (int o = 0; o < NO; o++) begin
        m_sel[o] = m_sh[o];
        m_sc[o] = 0;
      end
      m_state = 1;
    end
  endtask
  task automatic check_comb(input string tag);
    logic [NI-1:0] er;
    for (int i = 0; i < NI; i++) er[i] = m_rdy(i);
    chk({tag, ".in_ready"}, bus.in_ready, er);
    chk({tag, ".cfg_ready"}, bus.cfg_ready, m_state != 2);
    chk({tag, ".cfg_busy"}, bus.cfg_busy, m_state == 2);
  endtask
  task automatic check_regs(input string tag);
    logic [NO-1:0] ev;
    logic [127:0] ed;
    for (int o = 0; o < NO; o++) begin
      ev[o] = m_v[o];
      ed[o*32 +: 32] = m_d[o];
    end
    chk({tag, ".out_valid"}, bus.out_valid, ev);
    chk({tag, ".out_data"}, bus.out_data, ed);
`ifdef PE_XBAR_STALL_CNT_EN
    for (int o = 0; o < NO; o++) chk({tag, ".stall_cnt"}, bus.stall_cnt[o*16 +: 16], 16'(m_sc[o]));
`endif
  endtask
  task automatic step(input string tag);
    #1 check_comb(tag);
    @(posedge clk);
    m_clock();
    #1 check_regs(tag);
  endtask
  task automatic rand_data();
    for (int i = 0; i < NI; i++) bus.in_data[i*32 +: 32] = $urandom;
  endtask
  initial begin
    rst_n = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_sel = '0;
    bus.in_data = '0;
    bus.in_valid = '0;
    bus.out_ready = '0;
    m_reset();
    #3;
    chk("rst_out_valid", bus.out_valid, 4'h0);
    chk("rst_out_data", bus.out_data, 128'h0);
    chk("rst_cfg_ready", bus.cfg_ready, 1'b1);
    chk("rst_in_ready", bus.in_ready, 5'h0);
    step("rst");
    rst_n = 1'b1;
    step("idle");
    bus.cfg_valid = 1'b1;
    bus.cfg_sel = pk(0, 1, 2, 3);
    step("cfg0");
    bus.cfg_valid = 1'b0;
    bus.in_data = {32'hE, 32'hD, 32'hC, 32'hB, 32'hA};
    bus.in_valid = '1;
    bus.out_ready = '1;
    step("basic");
    chk("basic_data", bus.out_data, {32'hD, 32'hC, 32'hB, 32'hA});
    chk("basic_valid", bus.out_valid, 4'hF);
    for (int k = 0; k < 100; k++) begin
      rand_data();
      step("stream");
      chk("stream_full", bus.out_valid, 4'hF);
    end
    bus.in_valid = '0;
    bus.cfg_valid = 1'b1;
    bus.cfg_sel = pk(4, 4, 4, 4);
    step("mc_offer");
    bus.cfg_valid = 1'b0;
    step("mc_apply");
    bus.in_valid = 5'b10000;
    bus.in_data[128 +: 32] = 32'h4444_0001;
    step("mc_first");
    chk("mc_first_valid", bus.out_valid, 4'hF);
    chk("mc_first_data", bus.out_data, {4{32'h4444_0001}});
    bus.out_ready = 4'b1011;
    bus.in_data[128 +: 32] = 32'h4444_0002;
    #1 chk("mc_blocked", bus.in_ready[4], 1'b0);
    step("mc_stall");
    chk("mc_stall_valid", bus.out_valid, 4'b0100);
    chk("mc_stall_r2", bus.out_data[64 +: 32], 32'h4444_0001);
    bus.out_ready = '1;
    step("mc_release");
    chk("mc_release_valid", bus.out_valid, 4'hF);
    chk("mc_release_data", bus.out_data, {4{32'h4444_0002}});
    bus.in_valid = '0;
    bus.cfg_valid = 1'b1;
    bus.cfg_sel = pk(0, 1, 2, 7);
    step("dis_offer");
    bus.cfg_valid = 1'b0;
    step("dis_apply");
    for (int k = 0; k < 6; k++) begin
      rand_data();
      bus.in_valid = '1;
      bus.out_ready = 4'($urandom);
      #1 chk("dis_in_ready3", bus.in_ready[3], 1'b0);
      step("dis");
      chk("dis_valid3", bus.out_valid[3], 1'b0);
    end
    bus.in_valid = '0;
    bus.out_ready = '1;
    step("rc_flush");
    bus.in_valid = 5'b00010;
    bus.in_data[32 +: 32] = 32'h5151_5151;
    bus.out_ready = 4'b1101;
    step("rc_fill");
    chk("rc_r1_full", bus.out_valid[1], 1'b1);
    bus.in_valid = '0;
    bus.cfg_valid = 1'b1;
    bus.cfg_sel = pk(0, 0, 0, 0);
    step("rc_offer");
    bus.cfg_valid = 1'b0;
    bus.in_valid = '1;
    bus.in_data[0 +: 32] = 32'h0F0F_0F0F;
    chk("rc_busy", bus.cfg_busy, 1'b1);
    chk("rc_cfg_ready", bus.cfg_ready, 1'b0);
    chk("rc_in_ready", bus.in_ready, 5'h0);
    for (int k = 0; k < 3; k++) step("rc_hold");
    chk("rc_r1_data", bus.out_data[32 +: 32], 32'h5151_5151);
    chk("rc_r1_valid", bus.out_valid[1], 1'b1);
    bus.out_ready = '1;
    step("rc_apply");
    chk("rc_run", bus.cfg_busy, 1'b0);
    chk("rc_ready_back", bus.cfg_ready, 1'b1);
    step("rc_new");
    chk("rc_new_valid", bus.out_valid, 4'hF);
    chk("rc_new_data", bus.out_data, {4{32'h0F0F_0F0F}});
    for (int k = 0; k < 400; k++) begin
      rand_data();
      bus.in_valid = 5'($urandom);
      bus.out_ready = $urandom_range(0, 2) == 0 ? 4'($urandom) : 4'hF;
      if (!(bus.cfg_valid && !bus.cfg_ready)) begin
        bus.cfg_valid = $urandom_range(0, 19) == 0;
        bus.cfg_sel = pk($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
      end
      step("rand");
    end
    bus.cfg_valid = 1'b0;
    bus.in_valid = '0;
    bus.out_ready = '1;
    for (int k = 0; k < 3; k++) step("ar_flush");
    bus.cfg_valid = 1'b1;
    bus.cfg_sel = pk(0, 1, 2, 3);
    step("ar_offer");
    bus.cfg_valid = 1'b0;
    step("ar_apply");
    bus.in_valid = '1;
    rand_data();
    step("ar_fill");
    bus.out_ready = '0;
    step("ar_hold");
    chk("ar_full", bus.out_valid, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", bus.out_valid, 4'h0);
    chk("ar_out_data", bus.out_data, 128'h0);
    chk("ar_in_ready", bus.in_ready, 5'h0);
    chk("ar_cfg_ready", bus.cfg_ready, 1'b1);
    m_reset();
    @(posedge clk);
    #1;
    step("ar_rst");
    rst_n = 1'b1;
    step("ar_idle");
    chk("ar_idle_in_ready", bus.in_ready, 5'h0);
    chk("ar_idle_valid", bus.out_valid, 4'h0);
`ifdef PE_XBAR_STALL_CNT_EN
    bus.in_valid = '0;
    bus.out_ready = '1;
    bus.cfg_valid = 1'b1;
    bus.cfg_sel = pk(0, 1, 2, 3);
    step("sc_cfg");
    bus.cfg_valid = 1'b0;
    bus.in_valid = 5'b00001;
    step("sc_load");
    bus.in_valid = '0;
    bus.out_ready = 4'b1110;
    for (int k = 0; k < 10; k++) step("sc_stall");
    chk("sc_ten", bus.stall_cnt[15:0], 16'd10);
    for (int k = 0; k < 70000; k++) begin
      @(posedge clk);
      m_clock();
    end
    #1 chk("sc_sat", bus.stall_cnt[15:0], 16'hFFFF);
    bus.cfg_valid = 1'b1;
    step("sc_offer");
    bus.cfg_valid = 1'b0;
    bus.out_ready = '1;
    step("sc_apply");
    chk("sc_clear", bus.stall_cnt[15:0], 16'h0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
